// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment scan driver.
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;
  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef logic [2:0] digit_t;
endpackage

// File: rtl/seg7_scan_driver_hex.sv
// hex_to_seg7: nibble to active-low seven-segment pattern lookup.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX_SEG[nib_i];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit multiplexed hex display with per-frame snapshot, guard and blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 2000,
  parameter int NDIG  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     syscall_value,
  input  logic [14:0]     pc_value,
  input  logic            sel_pc,
  input  logic            blank_lead_zero,
  output logic [NDIG-1:0] an,
  output logic [6:0]      seg,
  output logic            dp
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] GEND = PW'(GUARD);
  logic [PW-1:0] presc_q, presc_d;
  digit_t digit_q, digit_d;
  logic [31:0] shadow_q, shadow_d;
  logic shadow_pc_q, shadow_pc_d;
  logic [NDIG-1:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, nib_seg;
  logic dp_q, dp_d;
  logic last_slot, frame_end, active, blanked;
  hex_to_seg7 u_hex (
    .nib_i(shadow_q[{digit_q, 2'b00} +: 4]),
    .seg_o(nib_seg)
  );
  always_comb begin
    last_slot   = presc_q == LAST;
    frame_end   = last_slot && digit_q == 3'd7;
    presc_d     = last_slot ? '0 : presc_q + 1'b1;
    digit_d     = last_slot ? digit_q + 3'd1 : digit_q;
    shadow_d    = frame_end ? (sel_pc ? {17'b0, pc_value} : syscall_value) : shadow_q;
    shadow_pc_d = frame_end ? sel_pc : shadow_pc_q;
    active      = presc_q >= GEND;
    // A digit is a leading zero when it and every higher nibble are zero
    blanked     = blank_lead_zero && digit_q != 3'd0 && (shadow_q >> {digit_q, 2'b00}) == 32'h0;
    an_d        = (active && !blanked) ? ~(NDIG'(1) << digit_q) : AN_OFF;
    seg_d       = (active && !blanked) ? nib_seg : SEG_BLANK;
    dp_d        = !(active && digit_q == 3'd0 && shadow_pc_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      digit_q     <= '0;
      shadow_q    <= 32'h0;
      shadow_pc_q <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      digit_q     <= digit_d;
      shadow_q    <= shadow_d;
      shadow_pc_q <= shadow_pc_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end
  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed frame-by-frame checks of the scan driver with DIV=4, GUARD=1.
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] syscall_value = 32'hDEADBEEF;
  logic [14:0] pc_value = 15'h1234;
  logic sel_pc = 1'b0;
  logic blank_lead_zero = 1'b0;
  logic [7:0] an;
  logic [6:0] seg;
  logic dp;
  int n_assert = 0;
  int n_fail = 0;
  logic [6:0] f1_seg [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] f3_seg [8] = '{7'h12, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  logic [6:0] pc_seg [4] = '{7'h0E, 7'h0E, 7'h0E, 7'h78};
  always #5 clk = ~clk;
  seg7_scan_driver #(.DIV(4), .GUARD(1), .NDIG(8)) dut (
    .clk(clk), .rst(rst), .syscall_value(syscall_value), .pc_value(pc_value),
    .sel_pc(sel_pc), .blank_lead_zero(blank_lead_zero), .an(an), .seg(seg), .dp(dp)
  );
  function automatic logic [7:0] on(input int s);
    return ~(8'd1 << s);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic slot(input string f, input int s, input logic [7:0] ea, input logic [6:0] es, input logic ed);
    tick;
    chk($sformatf("%s s%0d guard an", f, s), {24'h0, an}, {24'h0, 8'hFF});
    chk($sformatf("%s s%0d guard seg", f, s), {25'h0, seg}, {25'h0, 7'h7F});
    chk($sformatf("%s s%0d guard dp", f, s), {31'h0, dp}, 32'h1);
    repeat (3) begin
      tick;
      chk($sformatf("%s s%0d an", f, s), {24'h0, an}, {24'h0, ea});
      if (ea != 8'hFF) chk($sformatf("%s s%0d seg", f, s), {25'h0, seg}, {25'h0, es});
      chk($sformatf("%s s%0d dp", f, s), {31'h0, dp}, {31'h0, ed});
    end
  endtask
  initial begin
    repeat (3) begin
      tick;
      chk("reset an", {24'h0, an}, {24'h0, 8'hFF});
      chk("reset seg", {25'h0, seg}, {25'h0, 7'h7F});
      chk("reset dp", {31'h0, dp}, 32'h1);
    end
    rst = 1'b0;
    syscall_value = 32'h1234ABCD;
    for (int s = 0; s < 8; s++) slot("f0", s, on(s), 7'h40, 1'b1);
    for (int s = 0; s < 8; s++) begin
      if (s == 7) syscall_value = 32'h00000A05;
      slot("f1", s, on(s), f1_seg[s], 1'b1);
    end
    blank_lead_zero = 1'b1;
    for (int s = 0; s < 8; s++) slot("f2", s, s < 3 ? on(s) : 8'hFF, f3_seg[s], 1'b1);
    blank_lead_zero = 1'b0;
    for (int s = 0; s < 8; s++) begin
      if (s == 7) syscall_value = 32'h11111111;
      slot("f3", s, on(s), f3_seg[s], 1'b1);
    end
    for (int s = 0; s < 3; s++) slot("f4", s, on(s), 7'h79, 1'b1);
    tick;
    chk("f4 s3 guard an", {24'h0, an}, {24'h0, 8'hFF});
    tick;
    chk("f4 s3 an", {24'h0, an}, {24'h0, 8'hF7});
    chk("f4 s3 seg", {25'h0, seg}, {25'h0, 7'h79});
    syscall_value = 32'h22222222;
    repeat (2) begin
      tick;
      chk("f4 s3 tear seg", {25'h0, seg}, {25'h0, 7'h79});
    end
    for (int s = 4; s < 8; s++) slot("f4", s, on(s), 7'h79, 1'b1);
    slot("f5", 0, on(0), 7'h24, 1'b1);
    sel_pc = 1'b1;
    pc_value = 15'h7FFF;
    blank_lead_zero = 1'b1;
    for (int s = 1; s < 8; s++) slot("f5", s, on(s), 7'h24, 1'b1);
    for (int s = 0; s < 8; s++) slot("f6", s, s < 4 ? on(s) : 8'hFF, s < 4 ? pc_seg[s] : 7'h7F, s != 0);
    for (int s = 0; s < 5; s++) slot("f7", s, s < 4 ? on(s) : 8'hFF, s < 4 ? pc_seg[s] : 7'h7F, s != 0);
    repeat (2) tick;
    rst = 1'b1;
    tick;
    chk("midrst an", {24'h0, an}, {24'h0, 8'hFF});
    chk("midrst seg", {25'h0, seg}, {25'h0, 7'h7F});
    chk("midrst dp", {31'h0, dp}, 32'h1);
    rst = 1'b0;
    slot("post", 0, 8'hFE, 7'h40, 1'b1);
    slot("post", 1, 8'hFF, 7'h7F, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Display-side consumer of the CPU's `display_syscall` (32 b) and `display_pc` (15 b) outputs.
- Drives an 8-digit, common-anode, multiplexed seven-segment display on the FPGA board.
- Shows either value as hex. The value is snapshotted once per frame so digits never tear.
- Includes a per-digit ghosting guard interval and optional leading-zero blanking.

Parameters:
- DIV, 50000: clock cycles per digit slot (prescaler period); DIV >= 2.
- GUARD, 2000: cycles at the start of each slot with all anodes off; 1 <= GUARD < DIV.
- NDIG, 8: number of digits (fixed at 8; the parameter is for documentation and assertions only).

Ports:
- clk  in  1  system clock, same as CPU.
- rst  in  1  synchronous, active-high reset.
- syscall_value  in  32  value from CPU `display_syscall`.
- pc_value  in  15  value from CPU `display_pc`.
- sel_pc  in  1  0 = show syscall_value, 1 = show zero-extended pc_value.
- blank_lead_zero  in  1  1 = blank leading zero digits.
- an  out  8  anode enables, active-low; bit i = digit i (digit 0 = least significant nibble).
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset: all actions take effect on the clk edge where rst=1. rst has priority over every other event.
  - Internal state: presc=0, digit_idx=0, shadow=32'h0, shadow_pc=0.
  - Outputs: an=8'hFF, seg=7'h7F, dp=1.
- Prescaler: presc increments each cycle and wraps DIV-1 -> 0. On wrap, digit_idx increments, wrapping 7 -> 0.
- Frame boundary (presc==DIV-1 and digit_idx==7):
  - shadow <= sel_pc ? {17'b0, pc_value} : syscall_value.
  - shadow_pc <= sel_pc.
  - The display content for the whole next frame comes only from shadow/shadow_pc. Input changes mid-frame have no visible effect until the next frame.
- Outputs are registered: each cycle they are a function of the previous cycle's (presc, digit_idx, shadow, shadow_pc, blank_lead_zero).
  - Guard (presc < GUARD): an=8'hFF, seg=7'h7F, dp=1.
  - Active (presc >= GUARD): an = ~(1<<digit_idx); seg = hex pattern of nibble shadow[4*digit_idx +: 4].
- Blanking: digit i (i>0) is blanked when blank_lead_zero=1 and nibbles 7..i of shadow are all zero. A blanked digit gives an=8'hFF for the whole slot.
  - Digit 0 is never blanked; a value of 0 shows a single "0".
- dp: low only in the active phase of the digit-0 slot when shadow_pc=1 (marks PC mode); otherwise high.
- Hex patterns (active-low, hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Timing:
  - Frame length is 8*DIV cycles.
  - After rst deasserts, digit 0's slot starts immediately.
  - The first frame shows shadow=0.
  - The first input sample happens at the end of the first frame.
- Reset mid-frame: on the edge with rst=1, counters, shadow and outputs return to reset values; no partial-frame state is kept.
- sel_pc and blank_lead_zero are quasi-static inputs.
  - sel_pc is sampled only at the frame boundary.
  - blank_lead_zero is used live, in every cycle.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 7'h7F and AN_OFF = 8'hFF.
  - The 16-entry hex segment pattern constant array.
  - A digit-index typedef (3 b).
- Sub-module hex_to_seg7: combinational 4-bit nibble -> 7-bit active-low pattern lookup.
- The scan driver holds the prescaler, digit counter, shadow register, blanking logic and output registers.

Test Plan (DIV=4, GUARD=1 unless stated):
1. Reset: hold rst 3 cycles with inputs nonzero -> an=FF, seg=7F, dp=1 every cycle. After release, first frame: digit-0 slot shows an=FE, seg=40; other slots follow per blank_lead_zero.
2. syscall_value=32'h1234ABCD, sel_pc=0, blank=0; check the second frame.
   - Slot 0: an=FE seg=21. Slot 1: FD/46. Slot 2: FB/03. Slot 3: F7/08.
   - Slot 4: EF/19. Slot 5: DF/30. Slot 6: BF/24. Slot 7: 7F/79.
   - First cycle of each slot: an=FF.
3. Blanking: value 32'h00000A05, blank=1.
   - Slots 0..2 show 12, 40, 08.
   - Slots 3..7: an=FF for the whole slot.
   - With blank=0, slots 3..7 show 40.
4. Tearing: change syscall_value from 32'h11111111 to 32'h22222222 in the slot-3 active phase. Remaining slots of that frame still show 79; the next frame shows 24 in all slots.
5. PC mode: sel_pc=1, pc_value=15'h7FFF, blank=1. Next frame: slots 0..3 show 0E, 0E, 0E, 78; slots 4..7 blanked; dp=0 only in the slot-0 active phase.
6. Reset mid-frame: assert rst during the slot-5 active phase.
   - Next cycle: an=FF, seg=7F, dp=1.
   - After release: scan restarts at digit 0 with shadow=0, showing 40 in slot 0.
